pci_bus_arbiter: RTL

- Central PCI-style bus arbiter that shares the single AD/CBE/iframe/iready bus between up to five device instances.
- Grants follow round-robin fairness. The arbiter watches iframe and iready to find bus-idle boundaries.
- It enforces a grant-acceptance timeout and a latency timer so one master cannot starve the others.
- Optionally parks the bus on a default device when nobody is requesting.
- Sits between the testbench/device instances and replaces ad-hoc fixed-priority granting.

---
 rtl/pci_bus_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/pci_bus_arbiter.sv
// Round-robin PCI-style bus arbiter with grant timeout, latency timer and optional parking.
// Request/grant handshake: a device holds request low, is granted by a registered low grant bit, and owns the bus once its iframe is sampled low.
module pci_bus_arbiter #(
  parameter int N_REQ       = 5,
  parameter bit PARK_EN     = 1'b1,
  parameter int PARK_ID     = 0,
  parameter int GNT_TIMEOUT = 16,
  parameter int LAT_TIMER   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] request,
  input  logic             iframe,
  input  logic             iready,
  output logic [N_REQ-1:0] grant,
  output logic [2:0]       owner,
  output logic             owner_valid,
  output logic             bus_busy,
  output logic             gnt_timeout,
  output logic [1:0]       state_dbg
);

  localparam int GW = $clog2(GNT_TIMEOUT + 1);
  localparam int BW = $clog2(LAT_TIMER + 1);
  localparam logic [N_REQ-1:0] ONE      = N_REQ'(1);
  localparam logic [N_REQ-1:0] ONES     = '1;
  localparam logic [2:0]       PARK_IDX = 3'(PARK_ID);

  typedef enum logic [1:0] {IDLE, GRANT, BUSY, TURN} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [2:0]       owner_q, owner_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic [2:0]       winner;
  logic [GW-1:0]    gnt_cnt_q, gnt_cnt_d;
  logic [BW-1:0]    busy_cnt_q, busy_cnt_d, busy_inc;
  logic             gnt_timeout_q, gnt_timeout_d;
  logic             bus_idle, parked, found, owner_req, other_req;
  logic [N_REQ-1:0] owner_mask;
  logic [7:0]       req_pad;
  logic [3:0]       cand;

  assign bus_idle   = iframe & iready;
  assign owner_mask = ONE << owner_q;
  assign owner_req  = |(~request & owner_mask);
  assign other_req  = |(~request & ~owner_mask);
  assign parked     = PARK_EN && (state_q == IDLE) && (grant_q == ~(ONE << PARK_IDX));
  assign busy_inc   = (busy_cnt_q >= BW'(LAT_TIMER)) ? busy_cnt_q : busy_cnt_q + 1'b1;

  // Winner search starts one past the last owner and wraps.
  always_comb begin
    req_pad              = 8'hFF;
    req_pad[N_REQ-1:0]   = request;
    found                = 1'b0;
    winner               = '0;
    cand                 = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + 4'(i);
      if (cand >= 4'(N_REQ)) cand = cand - 4'(N_REQ);
      if (!found && !req_pad[cand[2:0]]) begin
        found  = 1'b1;
        winner = cand[2:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    gnt_cnt_d     = gnt_cnt_q;
    busy_cnt_d    = busy_cnt_q;
    gnt_timeout_d = 1'b0;
    unique case (state_q)
      // TURN arbitrates on its exit edge so the turnaround is exactly one all-ones cycle.
      IDLE, TURN: begin
        if (parked && !iframe) begin
          state_d    = BUSY;
          busy_cnt_d = '0;
          rr_ptr_d   = PARK_IDX;
          owner_d    = PARK_IDX;
        end else if (!bus_idle && !parked) begin
          state_d = IDLE;
          grant_d = ONES;
        end else if (found) begin
          if (parked && winner != PARK_IDX) begin
            state_d = IDLE;
            grant_d = ONES;
          end else begin
            state_d   = GRANT;
            grant_d   = ~(ONE << winner);
            owner_d   = winner;
            gnt_cnt_d = '0;
          end
        end else if (PARK_EN) begin
          state_d = IDLE;
          grant_d = ~(ONE << PARK_IDX);
          owner_d = PARK_IDX;
        end else begin
          state_d = IDLE;
          grant_d = ONES;
        end
      end
      GRANT: begin
        if (!iframe) begin
          state_d    = BUSY;
          busy_cnt_d = '0;
          rr_ptr_d   = owner_q;
        end else if (!owner_req) begin
          state_d = IDLE;
          grant_d = ONES;
        end else if (gnt_cnt_q == GW'(GNT_TIMEOUT - 1)) begin
          state_d       = IDLE;
          grant_d       = ONES;
          gnt_timeout_d = 1'b1;
          rr_ptr_d      = owner_q;
        end else begin
          gnt_cnt_d = gnt_cnt_q + 1'b1;
        end
      end
      BUSY: begin
        busy_cnt_d = busy_inc;
        if (bus_idle) begin
          state_d = TURN;
          grant_d = ONES;
        end else if (!owner_req || (busy_inc >= BW'(LAT_TIMER) && other_req)) begin
          grant_d = ONES;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = ONES;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= ONES;
      owner_q       <= '0;
      rr_ptr_q      <= 3'(N_REQ - 1);
      gnt_cnt_q     <= '0;
      busy_cnt_q    <= '0;
      gnt_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      gnt_cnt_q     <= gnt_cnt_d;
      busy_cnt_q    <= busy_cnt_d;
      gnt_timeout_q <= gnt_timeout_d;
    end
  end

  assign grant       = grant_q;
  assign owner       = owner_q;
  assign owner_valid = ~&grant_q;
  assign bus_busy    = (state_q == BUSY);
  assign gnt_timeout = gnt_timeout_q;
  assign state_dbg   = state_q;

endmodule
